// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the fetch-stage branch target buffer.
package branch_predictor_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        BP_STATIC_NT = 2'd0,
        BP_BIMODAL   = 2'd1,
        BP_HIT_TAKEN = 2'd2
    } bp_mode_t;

    localparam int unsigned BP_TARGET_W = 30;

    function automatic word_t seq_pc(input word_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, EX-stage training and perf-counter signals of the branch predictor.
interface branch_predictor_if #(
    parameter int unsigned PERF_W = 32
) ();
    import branch_predictor_pkg::*;

    word_t              if_pc;
    logic               pred_taken;
    word_t              pred_target;
    logic               upd_en;
    word_t              upd_pc;
    logic               upd_uncond;
    logic               upd_taken;
    word_t              upd_target;
    logic               upd_mispred;
    logic               bp_clear;
    logic [PERF_W-1:0]  perf_branches;
    logic [PERF_W-1:0]  perf_mispred;

    modport master (
        output if_pc, upd_en, upd_pc, upd_uncond, upd_taken, upd_target,
               upd_mispred, bp_clear,
        input  pred_taken, pred_target, perf_branches, perf_mispred
    );

    modport slave (
        input  if_pc, upd_en, upd_pc, upd_uncond, upd_taken, upd_target,
               upd_mispred, bp_clear,
        output pred_taken, pred_target, perf_branches, perf_mispred
    );

endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Combinational next-value logic for a W-bit saturating counter (load > set_max > inc > dec).
module sat_counter #(
    parameter int unsigned W = 2
) (
    input  logic [W-1:0] cur_i,
    input  logic         inc_i,
    input  logic         dec_i,
    input  logic         set_max_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] nxt_o
);

    always_comb begin
        nxt_o = cur_i;
        if (load_i) begin
            nxt_o = load_val_i;
        end else if (set_max_i) begin
            nxt_o = '1;
        end else if (inc_i) begin
            if (cur_i != '1) nxt_o = cur_i + W'(1);
        end else if (dec_i) begin
            if (cur_i != '0) nxt_o = cur_i - W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating counters: 0-cycle lookup at IF, trained from EX.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned CTR_W   = 2,
    parameter int unsigned MODE    = 1,
    parameter int unsigned PERF_W  = 32
) (
    input  logic               CLK,
    input  logic               nRST,
    branch_predictor_if.slave  bp
);

    localparam int unsigned IDX_W  = $clog2(ENTRIES);
    localparam bp_mode_t    MODE_E = bp_mode_t'(2'(MODE));

    typedef struct packed {
        logic                   valid;
        logic [TAG_W-1:0]       tag;
        logic [BP_TARGET_W-1:0] target;
        logic [CTR_W-1:0]       ctr;
    } btb_entry_t;

    btb_entry_t tbl_q [ENTRIES];

    // Lookup path
    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    btb_entry_t       rd_entry;
    logic             rd_hit;
    logic             pred_taken;

    assign rd_idx   = bp.if_pc[IDX_W+1:2];
    assign rd_tag   = bp.if_pc[IDX_W+2 +: TAG_W];
    assign rd_entry = tbl_q[rd_idx];
    assign rd_hit   = rd_entry.valid && (rd_entry.tag == rd_tag);

    always_comb begin
        pred_taken = 1'b0;
        case (MODE_E)
            BP_BIMODAL:   pred_taken = rd_hit && rd_entry.ctr[CTR_W-1];
            BP_HIT_TAKEN: pred_taken = rd_hit;
            default:      pred_taken = 1'b0;
        endcase
    end

    assign bp.pred_taken  = pred_taken;
    assign bp.pred_target = pred_taken ? {rd_entry.target, 2'b00} : seq_pc(bp.if_pc);

    // Update path
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    btb_entry_t       upd_entry;
    logic             upd_hit;
    logic [CTR_W-1:0] ctr_mid;
    logic [CTR_W-1:0] alloc_ctr;
    logic [CTR_W-1:0] ctr_d;
    btb_entry_t       wr_entry_d;
    logic             wr_en;

    assign upd_idx   = bp.upd_pc[IDX_W+1:2];
    assign upd_tag   = bp.upd_pc[IDX_W+2 +: TAG_W];
    assign upd_entry = tbl_q[upd_idx];
    assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

    always_comb begin
        ctr_mid            = '0;
        ctr_mid[CTR_W-1]   = 1'b1;
    end

    assign alloc_ctr = bp.upd_uncond ? '1 : ctr_mid;

    // A miss always loads the allocation value; the load is ignored unless taken.
    sat_counter #(.W(CTR_W)) u_entry_ctr (
        .cur_i      (upd_entry.ctr),
        .inc_i      (bp.upd_taken),
        .dec_i      (!bp.upd_taken),
        .set_max_i  (bp.upd_uncond),
        .load_i     (!upd_hit),
        .load_val_i (alloc_ctr),
        .nxt_o      (ctr_d)
    );

    always_comb begin
        wr_entry_d       = upd_entry;
        wr_entry_d.valid = 1'b1;
        wr_entry_d.tag   = upd_tag;
        wr_entry_d.ctr   = ctr_d;
        if (bp.upd_taken) wr_entry_d.target = bp.upd_target[31:2];
    end

    assign wr_en = bp.upd_en && (upd_hit || bp.upd_taken);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < ENTRIES; i++) tbl_q[i] <= '0;
        end else if (bp.bp_clear) begin
            for (int unsigned i = 0; i < ENTRIES; i++) tbl_q[i].valid <= 1'b0;
        end else if (wr_en) begin
            tbl_q[upd_idx] <= wr_entry_d;
        end
    end

    // Performance counters
    logic [PERF_W-1:0] perf_br_q, perf_br_d;
    logic [PERF_W-1:0] perf_mp_q, perf_mp_d;

    sat_counter #(.W(PERF_W)) u_perf_br (
        .cur_i      (perf_br_q),
        .inc_i      (1'b1),
        .dec_i      (1'b0),
        .set_max_i  (1'b0),
        .load_i     (1'b0),
        .load_val_i ('0),
        .nxt_o      (perf_br_d)
    );

    sat_counter #(.W(PERF_W)) u_perf_mp (
        .cur_i      (perf_mp_q),
        .inc_i      (1'b1),
        .dec_i      (1'b0),
        .set_max_i  (1'b0),
        .load_i     (1'b0),
        .load_val_i ('0),
        .nxt_o      (perf_mp_d)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_br_q <= '0;
            perf_mp_q <= '0;
        end else if (bp.upd_en) begin
            perf_br_q <= perf_br_d;
            if (bp.upd_mispred) perf_mp_q <= perf_mp_d;
        end
    end

    assign bp.perf_branches = perf_br_q;
    assign bp.perf_mispred  = perf_mp_q;

    logic unused_bits;
    assign unused_bits = ^{bp.if_pc, bp.upd_pc, bp.upd_target[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (ENTRIES=16, TAG_W=8, CTR_W=2, bimodal).
module tb_branch_predictor;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    int          checks   = 0;
    int          failures = 0;
    int unsigned exp_br   = 0;
    int unsigned exp_mp   = 0;

    branch_predictor_if #(.PERF_W(32)) bp ();

    branch_predictor #(
        .ENTRIES (16),
        .TAG_W   (8),
        .CTR_W   (2),
        .MODE    (1),
        .PERF_W  (32)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bp   (bp)
    );

    task automatic drive_idle();
        bp.upd_en      = 1'b0;
        bp.upd_pc      = '0;
        bp.upd_uncond  = 1'b0;
        bp.upd_taken   = 1'b0;
        bp.upd_target  = '0;
        bp.upd_mispred = 1'b0;
        bp.bp_clear    = 1'b0;
    endtask

    task automatic set_update(input logic [31:0] pc, input logic unc, input logic tk,
                              input logic [31:0] tgt, input logic mp, input logic clr);
        bp.upd_en      = 1'b1;
        bp.upd_pc      = pc;
        bp.upd_uncond  = unc;
        bp.upd_taken   = tk;
        bp.upd_target  = tgt;
        bp.upd_mispred = mp;
        bp.bp_clear    = clr;
    endtask

    task automatic do_update(input logic [31:0] pc, input logic unc, input logic tk,
                             input logic [31:0] tgt, input logic mp, input logic clr);
        set_update(pc, unc, tk, tgt, mp, clr);
        @(posedge CLK); #1;
        exp_br++;
        if (mp) exp_mp++;
        drive_idle();
    endtask

    task automatic test_reset();
        drive_idle();
        nRST     = 1'b0;
        bp.if_pc = 32'h0000_0040;
        #2;
        checks++; if ({bp.pred_taken, bp.pred_target} !== {1'b0, 32'h0000_0044}) begin failures++; $display("FAIL reset_pred got=%h exp=%h", {bp.pred_taken, bp.pred_target}, {1'b0, 32'h0000_0044}); end
        checks++; if (bp.perf_branches !== 32'd0) begin failures++; $display("FAIL reset_perf_br got=%0d exp=0", bp.perf_branches); end
        checks++; if (bp.perf_mispred !== 32'd0) begin failures++; $display("FAIL reset_perf_mp got=%0d exp=0", bp.perf_mispred); end
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_train();
        do_update(32'h40, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0);
        bp.if_pc = 32'h40; #1;
        checks++; if ({bp.pred_taken, bp.pred_target} !== {1'b1, 32'h0000_0100}) begin failures++; $display("FAIL train_hit got=%h exp=%h", {bp.pred_taken, bp.pred_target}, {1'b1, 32'h0000_0100}); end
        checks++; if (bp.perf_branches !== exp_br) begin failures++; $display("FAIL train_perf_br got=%0d exp=%0d", bp.perf_branches, exp_br); end
        checks++; if (bp.perf_mispred !== exp_mp) begin failures++; $display("FAIL train_perf_mp got=%0d exp=%0d", bp.perf_mispred, exp_mp); end
    endtask

    task automatic test_dec_saturate();
        do_update(32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        bp.if_pc = 32'h40; #1;
        checks++; if ({bp.pred_taken, bp.pred_target} !== {1'b0, 32'h0000_0044}) begin failures++; $display("FAIL dec_ctr1 got=%h exp=%h", {bp.pred_taken, bp.pred_target}, {1'b0, 32'h0000_0044}); end
        do_update(32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        do_update(32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        bp.if_pc = 32'h40; #1;
        checks++; if ({bp.pred_taken, bp.pred_target} !== {1'b0, 32'h0000_0044}) begin failures++; $display("FAIL dec_ctr0 got=%h exp=%h", {bp.pred_taken, bp.pred_target}, {1'b0, 32'h0000_0044}); end
        // counter held at 0, so one taken update reaches 1 (still not-taken)
        do_update(32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
        bp.if_pc = 32'h40; #1;
        checks++; if ({bp.pred_taken, bp.pred_target} !== {1'b0, 32'h0000_0044}) begin failures++; $display("FAIL dec_floor got=%h exp=%h", {bp.pred_taken, bp.pred_target}, {1'b0, 32'h0000_0044}); end
        do_update(32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
        bp.if_pc = 32'h40; #1;
        checks++; if ({bp.pred_taken, bp.pred_target} !== {1'b1, 32'h0000_0100}) begin failures++; $display("FAIL dec_recover got=%h exp=%h", {bp.pred_taken, bp.pred_target}, {1'b1, 32'h0000_0100}); end
    endtask

    task automatic test_alias();
        do_update(32'h80, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0);
        bp.if_pc = 32'h40; #1;
        checks++; if ({bp.pred_taken, bp.pred_target} !== {1'b0, 32'h0000_0044}) begin failures++; $display("FAIL alias_evicted got=%h exp=%h", {bp.pred_taken, bp.pred_target}, {1'b0, 32'h0000_0044}); end
        bp.if_pc = 32'h80; #1;
        checks++; if ({bp.pred_taken, bp.pred_target} !== {1'b1, 32'h0000_0200}) begin failures++; $display("FAIL alias_new got=%h exp=%h", {bp.pred_taken, bp.pred_target}, {1'b1, 32'h0000_0200}); end
    endtask

    task automatic test_uncond_and_sat();
        do_update(32'h1000, 1'b1, 1'b1, 32'h2000, 1'b0, 1'b0);
        do_update(32'h1000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        bp.if_pc = 32'h1000; #1;
        checks++; if ({bp.pred_taken, bp.pred_target} !== {1'b1, 32'h0000_2000}) begin failures++; $display("FAIL uncond_max got=%h exp=%h", {bp.pred_taken, bp.pred_target}, {1'b1, 32'h0000_2000}); end
        do_update(32'h1000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        bp.if_pc = 32'h1000; #1;
        checks++; if ({bp.pred_taken, bp.pred_target} !== {1'b0, 32'h0000_1004}) begin failures++; $display("FAIL uncond_dec2 got=%h exp=%h", {bp.pred_taken, bp.pred_target}, {1'b0, 32'h0000_1004}); end
        for (int i = 0; i < 3; i++) do_update(32'h44, 1'b0, 1'b1, 32'h500, 1'b0, 1'b0);
        do_update(32'h44, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        bp.if_pc = 32'h44; #1;
        checks++; if ({bp.pred_taken, bp.pred_target} !== {1'b1, 32'h0000_0500}) begin failures++; $display("FAIL inc_ceiling got=%h exp=%h", {bp.pred_taken, bp.pred_target}, {1'b1, 32'h0000_0500}); end
        do_update(32'h48, 1'b0, 1'b0, 32'h600, 1'b0, 1'b0);
        bp.if_pc = 32'h48; #1;
        checks++; if ({bp.pred_taken, bp.pred_target} !== {1'b0, 32'h0000_004C}) begin failures++; $display("FAIL no_alloc_nt got=%h exp=%h", {bp.pred_taken, bp.pred_target}, {1'b0, 32'h0000_004C}); end
        bp.if_pc = 32'hFFFF_FFFC; #1;
        checks++; if ({bp.pred_taken, bp.pred_target} !== {1'b0, 32'h0000_0000}) begin failures++; $display("FAIL pc_wrap got=%h exp=%h", {bp.pred_taken, bp.pred_target}, {1'b0, 32'h0000_0000}); end
    endtask

    task automatic test_clear_priority();
        do_update(32'h4C, 1'b0, 1'b1, 32'h300, 1'b1, 1'b1);
        bp.if_pc = 32'h44; #1;
        checks++; if ({bp.pred_taken, bp.pred_target} !== {1'b0, 32'h0000_0048}) begin failures++; $display("FAIL clear_old got=%h exp=%h", {bp.pred_taken, bp.pred_target}, {1'b0, 32'h0000_0048}); end
        bp.if_pc = 32'h4C; #1;
        checks++; if ({bp.pred_taken, bp.pred_target} !== {1'b0, 32'h0000_0050}) begin failures++; $display("FAIL clear_blocks_upd got=%h exp=%h", {bp.pred_taken, bp.pred_target}, {1'b0, 32'h0000_0050}); end
        checks++; if (bp.perf_branches !== exp_br) begin failures++; $display("FAIL clear_perf_br got=%0d exp=%0d", bp.perf_branches, exp_br); end
        checks++; if (bp.perf_mispred !== exp_mp) begin failures++; $display("FAIL clear_perf_mp got=%0d exp=%0d", bp.perf_mispred, exp_mp); end
    endtask

    task automatic test_same_cycle();
        bp.if_pc = 32'h54;
        set_update(32'h54, 1'b0, 1'b1, 32'h700, 1'b0, 1'b0);
        #1;
        checks++; if ({bp.pred_taken, bp.pred_target} !== {1'b0, 32'h0000_0058}) begin failures++; $display("FAIL same_alloc_pre got=%h exp=%h", {bp.pred_taken, bp.pred_target}, {1'b0, 32'h0000_0058}); end
        @(posedge CLK); #1;
        exp_br++;
        drive_idle();
        checks++; if ({bp.pred_taken, bp.pred_target} !== {1'b1, 32'h0000_0700}) begin failures++; $display("FAIL same_alloc_post got=%h exp=%h", {bp.pred_taken, bp.pred_target}, {1'b1, 32'h0000_0700}); end
        set_update(32'h54, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        checks++; if ({bp.pred_taken, bp.pred_target} !== {1'b1, 32'h0000_0700}) begin failures++; $display("FAIL same_dec_pre got=%h exp=%h", {bp.pred_taken, bp.pred_target}, {1'b1, 32'h0000_0700}); end
        @(posedge CLK); #1;
        exp_br++;
        drive_idle();
        checks++; if ({bp.pred_taken, bp.pred_target} !== {1'b0, 32'h0000_0058}) begin failures++; $display("FAIL same_dec_post got=%h exp=%h", {bp.pred_taken, bp.pred_target}, {1'b0, 32'h0000_0058}); end
        checks++; if (bp.perf_branches !== exp_br) begin failures++; $display("FAIL same_perf_br got=%0d exp=%0d", bp.perf_branches, exp_br); end
    endtask

    task automatic test_async_reset();
        do_update(32'h5C, 1'b0, 1'b1, 32'h800, 1'b0, 1'b0);
        set_update(32'h58, 1'b0, 1'b1, 32'h900, 1'b1, 1'b0);
        #2;
        nRST = 1'b0;
        #1;
        exp_br = 0;
        exp_mp = 0;
        checks++; if (bp.perf_branches !== 32'd0) begin failures++; $display("FAIL arst_perf_br got=%0d exp=0", bp.perf_branches); end
        bp.if_pc = 32'h5C; #1;
        checks++; if ({bp.pred_taken, bp.pred_target} !== {1'b0, 32'h0000_0060}) begin failures++; $display("FAIL arst_table got=%h exp=%h", {bp.pred_taken, bp.pred_target}, {1'b0, 32'h0000_0060}); end
        @(posedge CLK); #1;
        drive_idle();
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK); #1;
        bp.if_pc = 32'h58; #1;
        checks++; if ({bp.pred_taken, bp.pred_target} !== {1'b0, 32'h0000_005C}) begin failures++; $display("FAIL arst_no_write got=%h exp=%h", {bp.pred_taken, bp.pred_target}, {1'b0, 32'h0000_005C}); end
        checks++; if (bp.perf_mispred !== 32'd0) begin failures++; $display("FAIL arst_perf_mp got=%0d exp=0", bp.perf_mispred); end
    endtask

    initial begin
        test_reset();
        test_train();
        test_dec_saturate();
        test_alias();
        test_uncond_and_sat();
        test_clear_priority();
        test_same_cycle();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
